// File: rtl/riscv_nbit_pkg.sv
// Shared definitions for the riscv_nbit core:
// opcodes, instruction fields and FSM states.
package riscv_nbit_pkg;

   localparam int ILEN = 16;

   localparam int OP_HI  = 15;
   localparam int OP_LO  = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS1_HI = 8;
   localparam int RS1_LO = 6;
   localparam int RS2_HI = 5;
   localparam int RS2_LO = 3;
   localparam int IMM_HI = 5;
   localparam int IMM_LO = 0;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_LI   = 4'd7;
   localparam logic [3:0] OP_BNEZ = 4'd8;
   localparam logic [3:0] OP_JMP  = 4'd9;
   localparam logic [3:0] OP_HALT = 4'd15;

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

endpackage

// File: rtl/riscv_nbit_regfile.sv
// Register file: two async read ports, one sync write port.
// r0 and indices beyond NREGS read as zero and ignore writes.
module riscv_nbit_regfile #(
   parameter int XLEN  = 8,
   parameter int NREGS = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [2:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [2:0]      raddr1,
   input  logic [2:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic [XLEN-1:0] regs [NREGS];

   function automatic logic live(input logic [2:0] a);
      return (a != 3'd0) && (int'(a) < NREGS);
   endfunction

   assign rdata1 = live(raddr1) ? regs[raddr1[AW-1:0]] : '0;
   assign rdata2 = live(raddr2) ? regs[raddr2[AW-1:0]] : '0;

   // Write port; dropped writes leave the array untouched
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && live(waddr)) begin
         regs[waddr[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/riscv_nbit_core.sv
// Multi-cycle core: FETCH -> EXECUTE -> WRITEBACK, with
// branches, halt, run/stall, sticky illegal flag and retire count.
module riscv_nbit_core
   import riscv_nbit_pkg::*;
#(
   parameter int XLEN  = 8,
   parameter int NREGS = 4,
   parameter int PC_W  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   output logic [PC_W-1:0] imem_addr,
   input  logic [ILEN-1:0] imem_data,
   output logic [PC_W-1:0] pc,
   output logic [XLEN-1:0] result,
   output logic            carry,
   output logic            halted,
   output logic            illegal,
   output logic [15:0]     retired
);

   state_t          state;
   logic [ILEN-1:0] ir;
   logic [XLEN-1:0] a, b, alu, alu_q;
   logic [XLEN-1:0] imm_z, imm_s;
   logic [PC_W-1:0] npc, npc_q, tgt;
   logic [3:0]      op;
   logic            cout, wr, arith, bad, halt;
   logic            cout_q, wr_q, arith_q, halt_q;

   assign op        = ir[OP_HI:OP_LO];
   assign imm_z     = XLEN'(ir[IMM_HI:IMM_LO]);
   assign imm_s     = XLEN'($signed(ir[IMM_HI:IMM_LO]));
   assign tgt       = PC_W'(ir[IMM_HI:IMM_LO]);
   assign imem_addr = pc;

   riscv_nbit_regfile #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_rf (
      .clk    (clk),
      .reset  (reset),
      .we     ((state == S_WB) && wr_q),
      .waddr  (ir[RD_HI:RD_LO]),
      .wdata  (alu_q),
      .raddr1 (ir[RS1_HI:RS1_LO]),
      .raddr2 (ir[RS2_HI:RS2_LO]),
      .rdata1 (a),
      .rdata2 (b)
   );

   // ALU, carry and next-pc decode for the instruction in IR
   always_comb begin
      alu   = '0;
      cout  = 1'b0;
      wr    = 1'b0;
      arith = 1'b0;
      bad   = 1'b0;
      halt  = 1'b0;
      npc   = pc + PC_W'(1);
      unique case (op)
         OP_NOP: ;
         OP_ADD: begin
            {cout, alu} = {1'b0, a} + {1'b0, b};
            wr = 1'b1;
            arith = 1'b1;
         end
         OP_SUB: begin
            // carry is the inverted borrow: a + ~b + 1
            {cout, alu} = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
            wr = 1'b1;
            arith = 1'b1;
         end
         OP_AND: begin alu = a & b; wr = 1'b1; end
         OP_OR:  begin alu = a | b; wr = 1'b1; end
         OP_XOR: begin alu = a ^ b; wr = 1'b1; end
         OP_ADDI: begin
            {cout, alu} = {1'b0, a} + {1'b0, imm_s};
            wr = 1'b1;
            arith = 1'b1;
         end
         OP_LI:   begin alu = imm_z; wr = 1'b1; end
         OP_BNEZ: if (a != '0) npc = tgt;
         OP_JMP:  npc = tgt;
         OP_HALT: begin halt = 1'b1; npc = pc; end
         default: bad = 1'b1;
      endcase
   end

   // Instruction sequencer and architectural state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_FETCH;
         ir      <= '0;
         pc      <= '0;
         result  <= '0;
         carry   <= 1'b0;
         halted  <= 1'b0;
         illegal <= 1'b0;
         retired <= '0;
         alu_q   <= '0;
         npc_q   <= '0;
         cout_q  <= 1'b0;
         wr_q    <= 1'b0;
         arith_q <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         unique case (state)
            S_FETCH: if (run) begin
               ir    <= imem_data;
               state <= S_EXEC;
            end
            S_EXEC: begin
               alu_q   <= alu;
               cout_q  <= cout;
               npc_q   <= npc;
               wr_q    <= wr;
               arith_q <= arith;
               halt_q  <= halt;
               if (bad) illegal <= 1'b1;
               state <= S_WB;
            end
            S_WB: begin
               if (wr_q) result <= alu_q;
               if (arith_q) carry <= cout_q;
               pc <= npc_q;
               if (retired != 16'hFFFF) retired <= retired + 16'd1;
               if (halt_q) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  state <= S_FETCH;
               end
            end
            S_HALT: ;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_nbit_core.sv
// Scoreboard bench: an ISA-level model fills per-DUT queues of expected
// retirements; monitors pop and compare on every retire-count change.
module tb_riscv_nbit_core;

   typedef struct {
      int pc;
      int result;
      int carry;
      int halted;
      int illegal;
      int retired;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b1;
   logic [15:0] rom [16];
   int          cyc = 0;
   int          vec = 0;
   int          errs = 0;
   exp_t        q8[$];
   exp_t        q4[$];
   int          prev8 = 0;
   int          prev4 = 0;

   logic [3:0]  addr8, pc8, addr4, pc4;
   logic [7:0]  res8;
   logic [3:0]  res4;
   logic        c8, h8, il8, c4, h4, il4;
   logic [15:0] ret8, ret4;

   always #5 clk = ~clk;

   riscv_nbit_core #(.XLEN(8), .NREGS(4), .PC_W(4)) dut8 (
      .clk(clk), .reset(reset), .run(run),
      .imem_addr(addr8), .imem_data(rom[addr8]),
      .pc(pc8), .result(res8), .carry(c8),
      .halted(h8), .illegal(il8), .retired(ret8)
   );

   riscv_nbit_core #(.XLEN(4), .NREGS(4), .PC_W(4)) dut4 (
      .clk(clk), .reset(reset), .run(run),
      .imem_addr(addr4), .imem_data(rom[addr4]),
      .pc(pc4), .result(res4), .carry(c4),
      .halted(h4), .illegal(il4), .retired(ret4)
   );

   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      vec++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_all(input string tag, input exp_t e,
                          input int p, input int r, input int c,
                          input int h, input int il, input int rt);
      chk({tag, ".pc"}, p, e.pc);
      chk({tag, ".result"}, r, e.result);
      chk({tag, ".carry"}, c, e.carry);
      chk({tag, ".halted"}, h, e.halted);
      chk({tag, ".illegal"}, il, e.illegal);
      chk({tag, ".retired"}, rt, e.retired);
      if (e.cyc >= 0) chk({tag, ".edge"}, cyc, e.cyc);
   endtask

   always @(negedge clk) begin
      if (reset) prev8 = 0;
      else if (int'(ret8) != prev8) begin
         prev8 = int'(ret8);
         if (q8.size() == 0) chk("x8.extra_retire", int'(ret8), -1);
         else cmp_all("x8", q8.pop_front(), int'(pc8), int'(res8),
                      int'(c8), int'(h8), int'(il8), int'(ret8));
      end
   end

   always @(negedge clk) begin
      if (reset) prev4 = 0;
      else if (int'(ret4) != prev4) begin
         prev4 = int'(ret4);
         if (q4.size() == 0) chk("x4.extra_retire", int'(ret4), -1);
         else cmp_all("x4", q4.pop_front(), int'(pc4), int'(res4),
                      int'(c4), int'(h4), int'(il4), int'(ret4));
      end
   end

   function automatic logic [15:0] enc(input int op, input int rd,
                                       input int rs1, input int lo);
      return {op[3:0], rd[2:0], rs1[2:0], lo[5:0]};
   endfunction

   // ISA-level reference: executes from reset for up to n instructions
   task automatic model_run(input int w, input int n, input bit timed);
      int regs [8];
      int pc, res, cy, il, ret, mask, a, b, v, imm, simm, npc, rd;
      bit wr, hlt;
      logic [15:0] ins;
      exp_t e;
      for (int i = 0; i < 8; i++) regs[i] = 0;
      mask = (1 << w) - 1;
      pc = 0; res = 0; cy = 0; il = 0; ret = 0;
      for (int k = 0; k < n; k++) begin
         ins  = rom[pc];
         imm  = int'(ins[5:0]);
         simm = (imm >= 32) ? imm - 64 : imm;
         a    = (ins[8:6] < 4) ? regs[ins[8:6]] : 0;
         b    = (ins[5:3] < 4) ? regs[ins[5:3]] : 0;
         rd   = int'(ins[11:9]);
         npc  = (pc + 1) % 16;
         wr   = 0; hlt = 0; v = 0;
         case (ins[15:12])
            4'd0: ;
            4'd1: begin v = a + b; cy = int'(v > mask); wr = 1; end
            4'd2: begin v = a - b; cy = int'(a >= b); wr = 1; end
            4'd3: begin v = a & b; wr = 1; end
            4'd4: begin v = a | b; wr = 1; end
            4'd5: begin v = a ^ b; wr = 1; end
            4'd6: begin v = a + (simm & mask); cy = int'(v > mask); wr = 1; end
            4'd7: begin v = imm; wr = 1; end
            4'd8: if (a != 0) npc = imm % 16;
            4'd9: npc = imm % 16;
            4'd15: begin hlt = 1; npc = pc; end
            default: il = 1;
         endcase
         if (wr) begin
            res = v & mask;
            if (rd != 0 && rd < 4) regs[rd] = res;
         end
         pc = npc;
         ret++;
         e = '{pc, res, cy, int'(hlt), il, ret, timed ? 3 * (k + 1) : -1};
         if (w == 8) q8.push_back(e);
         else q4.push_back(e);
         if (hlt) break;
      end
   endtask

   task automatic start(input int n, input bit timed);
      reset = 1'b1;
      run = 1'b1;
      @(negedge clk);
      q8.delete();
      q4.delete();
      model_run(8, n, timed);
      model_run(4, n, timed);
      reset = 1'b0;
   endtask

   task automatic drain(input int budget, input bit stall);
      int t = 0;
      while ((q8.size() != 0 || q4.size() != 0) && t < budget) begin
         @(negedge clk);
         t++;
         if (stall) run = 1'($urandom_range(0, 1));
      end
      chk("drain_left", q8.size() + q4.size(), 0);
      q8.delete();
      q4.delete();
      run = 1'b1;
      reset = 1'b1;
   endtask

   task automatic run_prog(input int n, input bit stall);
      start(n, !stall);
      drain(12 * n + 30, stall);
   endtask

   task automatic clear_rom;
      for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
   endtask

   task automatic wait_edge(input int target);
      int t = 0;
      while (cyc != target && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("wait_edge", cyc, target);
   endtask

   initial begin
      clear_rom();
      @(negedge clk);
      @(negedge clk);
      chk("rst.pc", int'(pc8), 0);
      chk("rst.imem_addr", int'(addr8), 0);
      chk("rst.result", int'(res8), 0);
      chk("rst.carry", int'(c8), 0);
      chk("rst.halted", int'(h8), 0);
      chk("rst.illegal", int'(il8), 0);
      chk("rst.retired", int'(ret8), 0);
      chk("rst.result4", int'(res4), 0);

      // LI r1,3; LI r2,5; ADD r3,r1,r2; HALT
      clear_rom();
      rom[0] = enc(7, 1, 0, 3);
      rom[1] = enc(7, 2, 0, 5);
      rom[2] = enc(1, 3, 1, 2 << 3);
      rom[3] = enc(15, 0, 0, 0);
      run_prog(10, 0);

      // countdown loop
      clear_rom();
      rom[0] = enc(7, 1, 0, 3);
      rom[1] = enc(6, 1, 1, 63);
      rom[2] = enc(8, 0, 1, 1);
      rom[3] = enc(15, 0, 0, 0);
      run_prog(20, 0);

      // sixteen NOPs, pc wraps back to 0
      clear_rom();
      run_prog(16, 0);

      // overflow and borrow cases
      clear_rom();
      rom[0] = enc(7, 1, 0, 63);
      rom[1] = enc(1, 2, 1, 1 << 3);
      rom[2] = enc(1, 2, 2, 2 << 3);
      rom[3] = enc(2, 3, 0, 1 << 3);
      rom[4] = enc(2, 3, 1, 0);
      rom[5] = enc(6, 0, 1, 1);
      rom[6] = enc(6, 5, 1, 2);
      rom[7] = enc(9, 0, 0, 9);
      rom[9] = enc(15, 0, 0, 0);
      run_prog(20, 0);

      // run held low for 5 cycles before the third fetch
      clear_rom();
      for (int i = 0; i < 8; i++) rom[i] = enc(7, 1, 0, i + 1);
      rom[8] = enc(15, 0, 0, 0);
      start(20, 0);
      wait_edge(6);
      run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall.pc", int'(pc8), 2);
         chk("stall.retired", int'(ret8), 2);
         chk("stall.imem_addr", int'(addr8), 2);
      end
      run = 1'b1;
      drain(100, 0);

      // reset during WRITEBACK of the ADD
      clear_rom();
      rom[0] = enc(7, 1, 0, 3);
      rom[1] = enc(7, 2, 0, 5);
      rom[2] = enc(1, 3, 1, 2 << 3);
      rom[3] = enc(15, 0, 0, 0);
      start(2, 1);
      wait_edge(8);
      reset = 1'b1;
      #1;
      chk("rstwb.result", int'(res8), 0);
      chk("rstwb.pc", int'(pc8), 0);
      chk("rstwb.retired", int'(ret8), 0);
      chk("rstwb.carry", int'(c8), 0);
      chk("rstwb.pending", q8.size() + q4.size(), 0);

      // r3 must still be zero; opcode 12 sets sticky illegal
      clear_rom();
      rom[0] = enc(6, 1, 3, 0);
      rom[1] = 16'hC000;
      rom[2] = enc(7, 2, 0, 1);
      rom[3] = enc(15, 0, 0, 0);
      run_prog(10, 0);
      #1;
      chk("illegal_cleared", int'(il8), 0);

      // random programs, half with random run stalls
      for (int p = 0; p < 12; p++) begin
         for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
         run_prog(40, (p % 2) == 1);
      end

      reset = 1'b1;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
